// File: rtl/multdiv_sequencer_if.sv
// Signal bundle between the execute stage, the multdiv sequencer and the multi-cycle unit.
// slave = sequencer side, master = pipeline/unit environment side.
interface multdiv_sequencer_if #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
);
  // pipeline request
  logic                start_mult;
  logic                start_div;
  logic [WIDTH-1:0]    operand_a;
  logic [WIDTH-1:0]    operand_b;
  logic [REG_BITS-1:0] dest_reg;

  // multiply/divide unit
  logic                md_ctrl_MULT;
  logic                md_ctrl_DIV;
  logic [WIDTH-1:0]    md_operandA;
  logic [WIDTH-1:0]    md_operandB;
  logic [WIDTH-1:0]    md_result;
  logic                md_exception;
  logic                md_resultRDY;

  // pipeline control and X/M hand-off
  logic                stall;
  logic                busy;
  logic [REG_BITS-1:0] busy_dest;
  logic                result_valid;
  logic [WIDTH-1:0]    result;
  logic [REG_BITS-1:0] result_dest;
  logic                result_exception;

  modport slave (
    input  start_mult, start_div, operand_a, operand_b, dest_reg,
    input  md_result, md_exception, md_resultRDY,
    output md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
    output stall, busy, busy_dest,
    output result_valid, result, result_dest, result_exception
  );

  modport master (
    output start_mult, start_div, operand_a, operand_b, dest_reg,
    output md_result, md_exception, md_resultRDY,
    input  md_ctrl_MULT, md_ctrl_DIV, md_operandA, md_operandB,
    input  stall, busy, busy_dest,
    input  result_valid, result, result_dest, result_exception
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the multi-cycle multiply/divide unit: issue, stall, hand off.
// Define MULTDIV_TIMEOUT_EN to build a WAIT watchdog that aborts after TIMEOUT_CYCLES.
//
//   state | meaning
//   IDLE  | waiting for start_mult/start_div; operands latched on the sample edge
//   ISSUE | one-cycle md_ctrl_* pulse to the unit
//   WAIT  | pipeline stalled until md_resultRDY (or watchdog expiry)
//   DONE  | one-cycle result_valid strobe with the unit's result
//   DZERO | one-cycle result_valid strobe for divide-by-zero, unit untouched
module multdiv_sequencer #(
  parameter int WIDTH          = 32,
  parameter int REG_BITS       = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  multdiv_sequencer_if.slave md
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DZERO = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    op_a_q, op_a_d;
  logic [WIDTH-1:0]    op_b_q, op_b_d;
  logic [REG_BITS-1:0] dest_q, dest_d;
  logic                is_div_q, is_div_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                exc_q, exc_d;

  logic                start_any;
  logic                stall;
  logic                busy;
  logic                ctrl_mult;
  logic                ctrl_div;
  logic                valid;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Without the watchdog the limit has no hardware; this only keeps it referenced.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign start_any = md.start_mult | md.start_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      dest_q   <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      dest_q   <= dest_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

`ifdef MULTDIV_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    dest_d    = dest_q;
    is_div_d  = is_div_q;
    result_d  = result_q;
    exc_d     = exc_q;
    stall     = 1'b0;
    busy      = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    valid     = 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Freeze the pipeline in the very cycle the request is seen.
        stall = start_any;
        if (start_any) begin
          op_a_d   = md.operand_a;
          op_b_d   = md.operand_b;
          dest_d   = md.dest_reg;
          is_div_d = ~md.start_mult;
          if (!md.start_mult && (md.operand_b == '0)) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = S_DZERO;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        stall     = 1'b1;
        busy      = 1'b1;
        ctrl_mult = ~is_div_q;
        ctrl_div  = is_div_q;
        state_d   = S_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      S_WAIT: begin
        stall = 1'b1;
        busy  = 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (md.md_resultRDY) begin
          result_d = md.md_result;
          exc_d    = md.md_exception;
          state_d  = S_DONE;
`ifdef MULTDIV_TIMEOUT_EN
        end else if (cnt_d == CNT_LIMIT) begin
          // Abort is reported as an exception with a zero result.
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = S_DONE;
`endif
        end
      end

      S_DONE: begin
        valid   = 1'b1;
        state_d = S_IDLE;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_DZERO: begin
        valid   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign md.md_ctrl_MULT     = ctrl_mult;
  assign md.md_ctrl_DIV      = ctrl_div;
  assign md.md_operandA      = op_a_q;
  assign md.md_operandB      = op_b_q;
  assign md.stall            = stall;
  assign md.busy             = busy;
  assign md.busy_dest        = busy ? dest_q : '0;
  assign md.result_valid     = valid;
  assign md.result           = result_q;
  assign md.result_dest      = dest_q;
  assign md.result_exception = exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed cases plus randomized ops
// against an arithmetic reference model and a behavioural multi-cycle unit.
module tb_multdiv_sequencer;
  localparam int WIDTH    = 32;
  localparam int REG_BITS = 5;
  localparam int TO       = 64;
  localparam int UNIT_LAT = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multdiv_sequencer_if #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) bus ();

  multdiv_sequencer #(
    .WIDTH(WIDTH), .REG_BITS(REG_BITS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .md   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: signed product/quotient truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] ref_result(input bit is_div, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div)      r = sa * sb;
    else if (sb == 0) r = 0;
    else              r = sa / sb;
    return r[WIDTH-1:0];
  endfunction

  function automatic logic ref_exc(input bit is_div, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end
    if (sb == 0) return 1'b1;
    return (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl_mult"}, bus.md_ctrl_MULT, 0);
    chk({tag, "_ctrl_div"},  bus.md_ctrl_DIV, 0);
    chk({tag, "_opA"},       bus.md_operandA, 0);
    chk({tag, "_opB"},       bus.md_operandB, 0);
    chk({tag, "_stall"},     bus.stall, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_busy_dest"}, bus.busy_dest, 0);
    chk({tag, "_valid"},     bus.result_valid, 0);
    chk({tag, "_result"},    bus.result, 0);
    chk({tag, "_rdest"},     bus.result_dest, 0);
    chk({tag, "_rexc"},      bus.result_exception, 0);
  endtask

  // One complete operation. Cycle 0 is the sample cycle; the unit answers lat
  // cycles after it sees the issue pulse. no_rdy models a unit that never answers.
  task automatic run_op(input string nm, input bit sm, input bit sd,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [REG_BITS-1:0] rd, input int lat,
                        input bit stale, input bit no_rdy);
    bit is_div, dz;
    int exp_lat, n_mult, n_div, stall_cnt, busy_cnt, seen_at, rdy_at;
    logic [WIDTH-1:0] ua, ub, exp_res;
    logic exp_exc;
    bit uop_div;
    is_div    = sd && !sm;
    dz        = is_div && (b == '0);
    exp_lat   = dz ? 1 : (no_rdy ? TO + 2 : lat + 2);
    exp_res   = no_rdy ? '0 : ref_result(is_div, a, b);
    exp_exc   = no_rdy ? 1'b1 : ref_exc(is_div, a, b);
    n_mult    = 0; n_div = 0; stall_cnt = 0; busy_cnt = 0;
    seen_at   = -1; rdy_at = -1;
    ua = '0; ub = '0; uop_div = 1'b0;
    for (int cyc = 0; cyc < exp_lat + 40 && seen_at < 0; cyc++) begin
      @(negedge clock);
      bus.md_resultRDY = 1'b0;
      if (cyc == 0) begin
        bus.start_mult = sm;
        bus.start_div  = sd;
        bus.operand_a  = a;
        bus.operand_b  = b;
        bus.dest_reg   = rd;
      end
      if (cyc == rdy_at && !no_rdy) begin
        bus.md_resultRDY = 1'b1;
        bus.md_result    = ref_result(uop_div, ua, ub);
        bus.md_exception = ref_exc(uop_div, ua, ub);
      end
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.busy)  busy_cnt++;
      if (bus.md_ctrl_MULT) n_mult++;
      if (bus.md_ctrl_DIV)  n_div++;
      if (rdy_at < 0 && (bus.md_ctrl_MULT || bus.md_ctrl_DIV)) begin
        ua      = bus.md_operandA;
        ub      = bus.md_operandB;
        uop_div = bus.md_ctrl_DIV;
        rdy_at  = cyc + lat;
        chk({nm, "_issue_cyc"}, cyc, 1);
        chk({nm, "_opA"}, ua, a);
        chk({nm, "_opB"}, ub, b);
        chk({nm, "_busy_dest"}, bus.busy_dest, rd);
        if (stale) begin
          bus.md_resultRDY = 1'b1;
          bus.md_result    = 32'hDEAD_BEEF;
          bus.md_exception = 1'b1;
        end
      end
      if (bus.result_valid) begin
        seen_at = cyc;
        chk({nm, "_result"}, bus.result, exp_res);
        chk({nm, "_rdest"},  bus.result_dest, rd);
        chk({nm, "_rexc"},   bus.result_exception, exp_exc);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
      end
    end
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    chk({nm, "_latency"}, seen_at, exp_lat);
    chk({nm, "_stall_cycles"}, stall_cnt, exp_lat);
    chk({nm, "_busy_cycles"}, busy_cnt, dz ? 0 : exp_lat - 1);
    chk({nm, "_mult_pulses"}, n_mult, is_div ? 0 : 1);
    chk({nm, "_div_pulses"},  n_div, (is_div && !dz) ? 1 : 0);
    @(negedge clock);
    bus.md_resultRDY = 1'b0;
    #1;
    chk({nm, "_valid_1cyc"}, bus.result_valid, 0);
    chk({nm, "_busy_after"}, bus.busy, 0);
    chk({nm, "_opA_hold"}, bus.md_operandA, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int issue, rdy_at, valid_seen, active, n_ctrl;
    logic [WIDTH-1:0] ra, rb;
    bit rm, rdv;
    bus.start_mult   = 1'b0;
    bus.start_div    = 1'b0;
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    bus.dest_reg     = '0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    run_op("mult_7x-3", 1'b1, 1'b0, 32'd7, -32'sd3, 5'd8, UNIT_LAT, 1'b0, 1'b0);
    run_op("div_293435", 1'b0, 1'b1, 32'd293435, 32'd1, 5'd9, UNIT_LAT, 1'b0, 1'b0);
    run_op("div_neg", 1'b0, 1'b1, -32'sd17260, 32'd5, 5'd10, UNIT_LAT, 1'b1, 1'b0);
    run_op("div_zero", 1'b0, 1'b1, 32'd5, 32'd0, 5'd11, UNIT_LAT, 1'b0, 1'b0);
    run_op("both_start", 1'b1, 1'b1, 32'd6, 32'd2, 5'd12, UNIT_LAT, 1'b0, 1'b0);
    run_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 3, 1'b1, 1'b0);
    run_op("mult_ovf", 1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd1, 1, 1'b1, 1'b0);

    // Randomized ops against the reference model.
    for (int k = 0; k < 30; k++) begin
      rm  = ($urandom_range(0, 2) == 0);
      rdv = !rm || ($urandom_range(0, 3) == 0);
      ra  = $urandom();
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($signed($urandom_range(0, 40)) - 20);
        2:       rb = $urandom();
        default: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
      endcase
      run_op("rand", rm, rdv, ra, rb, 5'($urandom_range(0, 31)),
             $urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Reset at WAIT cycle 10; the unit's late answer must be ignored.
    @(negedge clock);
    bus.start_mult = 1'b1;
    bus.operand_a  = 32'd100;
    bus.operand_b  = 32'd3;
    bus.dest_reg   = 5'd7;
    issue = -1; rdy_at = -1; valid_seen = 0; active = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clock);
      bus.md_resultRDY = 1'b0;
      if (c == rdy_at) begin
        bus.md_resultRDY = 1'b1;
        bus.md_result    = 32'd300;
        bus.md_exception = 1'b1;
      end
      #1;
      if (issue < 0 && bus.md_ctrl_MULT) begin
        issue  = c;
        rdy_at = c + UNIT_LAT;
      end
      if (issue > 0 && c == issue + 10) begin
        chk("midrst_busy_before", bus.busy, 1);
        reset = 1'b0;
        bus.start_mult = 1'b0;
        #1;
        check_all_zero("midrst");
      end
      if (issue > 0 && c == issue + 11) reset = 1'b1;
      if (issue > 0 && c > issue + 10 && (bus.stall || bus.busy)) active++;
      if (bus.result_valid) valid_seen++;
    end
    chk("midrst_issue", issue, 1);
    chk("midrst_no_valid", valid_seen, 0);
    chk("midrst_idle_after", active, 0);

`ifdef MULTDIV_TIMEOUT_EN
    run_op("timeout", 1'b1, 1'b0, 32'd3, 32'd4, 5'd3, UNIT_LAT, 1'b0, 1'b1);
`else
    // Silent unit: the sequencer keeps the pipeline stalled indefinitely.
    @(negedge clock);
    bus.start_mult = 1'b1;
    bus.operand_a  = 32'd3;
    bus.operand_b  = 32'd4;
    bus.dest_reg   = 5'd3;
    valid_seen = 0; n_ctrl = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      #1;
      if (bus.result_valid) valid_seen++;
      if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) n_ctrl++;
    end
    chk("hang_stall", bus.stall, 1);
    chk("hang_busy", bus.busy, 1);
    chk("hang_no_valid", valid_seen, 0);
    chk("hang_one_issue", n_ctrl, 1);
    @(negedge clock);
    reset = 1'b0;
    bus.start_mult = 1'b0;
    #1;
    check_all_zero("hang_rst");
    @(negedge clock);
    reset = 1'b1;
`endif

    run_op("post_mult", 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd9, 5'd21, 5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
